// File: rtl/div_seq.sv
// Sequential restoring divider for MIPS DIV/DIVU: one quotient bit per clock,
// quotient on LO (quotient) and remainder on HI (remainder).
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    // Handshake: start is sampled only while busy=0; the result appears with a
    // one-cycle done pulse WIDTH+1 cycles after acceptance, and holds until the
    // next completion or reset.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg;
    logic             dsr_neg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             trial_ge;

    // Partial remainder stays below the divisor, so a WIDTH+1-bit difference
    // never overflows and its top bit is the borrow.
    always_comb begin
        dvd_neg  = signed_op & dividend[WIDTH-1];
        dsr_neg  = signed_op & divisor[WIDTH-1];
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dsr_q};
        trial_ge = ~trial[WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        dvd_raw_d   = dvd_raw_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    neg_quo_d = dvd_neg ^ dsr_neg;
                    neg_rem_d = dvd_neg;
                    quo_d     = dvd_neg ? (~dividend + 1'b1) : dividend;
                    dsr_d     = dsr_neg ? (~divisor + 1'b1) : divisor;
                    dvd_raw_d = dividend;
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                rem_d = trial_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], trial_ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A zero divisor magnitude means the captured divisor was zero.
                if (dsr_q == '0) begin
                    quotient_d  = '1;
                    remainder_d = dvd_raw_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                    remainder_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                    dbz_d       = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            dvd_raw_q   <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            dvd_raw_q   <= dvd_raw_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: a 32-bit instance for directed/random operations and a
// 4-bit instance swept exhaustively, both checked through an expected queue.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;

    logic        start32, signed32, busy32, done32, dbz32;
    logic [31:0] dvd32, dvs32, quo32, rem32;
    logic        start4, signed4, busy4, done4, dbz4;
    logic [3:0]  dvd4, dvs4, quo4, rem4;

    logic [64:0] exp32_q[$];
    int          acc32_q[$];
    logic [8:0]  exp4_q[$];
    int          acc4_q[$];
    logic        done32_prev = 1'b0;
    logic        done4_prev = 1'b0;

    div_seq #(.WIDTH(32), .CW(6)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .signed_op(signed32),
        .dividend(dvd32), .divisor(dvs32), .quotient(quo32), .remainder(rem32),
        .busy(busy32), .done(done32), .div_by_zero(dbz32)
    );

    div_seq #(.WIDTH(4), .CW(3)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .signed_op(signed4),
        .dividend(dvd4), .divisor(dvs4), .quotient(quo4), .remainder(rem4),
        .busy(busy4), .done(done4), .div_by_zero(dbz4)
    );

    // clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: {div_by_zero, remainder, quotient} on 32-bit operands.
    function automatic logic [64:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {(b == 32'd0), r, q};
    endfunction

    // driver tasks: called at a negedge while the DUT is idle
    task automatic drive32(input logic s, input logic [31:0] a, input logic [31:0] b);
        signed32 = s;
        dvd32    = a;
        dvs32    = b;
        start32  = 1'b1;
        exp32_q.push_back(ref_div(s, a, b));
        acc32_q.push_back(cyc + 1);
        @(negedge clk);
        start32  = 1'b0;
        dvd32    = $urandom();
        dvs32    = $urandom();
        signed32 = ~s;
    endtask

    task automatic wait_done32();
        int n = 0;
        while (!done32 && n < 60) begin
            check("busy32_running", 64'(busy32), 64'd1);
            @(negedge clk);
            n++;
        end
        check("done32_seen", 64'(done32), 64'd1);
    endtask

    task automatic drive4(input logic s, input logic [3:0] a, input logic [3:0] b);
        logic [31:0] ax;
        logic [31:0] bx;
        logic [64:0] r;
        ax = s ? {{28{a[3]}}, a} : {28'd0, a};
        bx = s ? {{28{b[3]}}, b} : {28'd0, b};
        r  = ref_div(s, ax, bx);
        signed4 = s;
        dvd4    = a;
        dvs4    = b;
        start4  = 1'b1;
        exp4_q.push_back({r[64], r[35:32], r[3:0]});
        acc4_q.push_back(cyc + 1);
        @(negedge clk);
        start4  = 1'b0;
        dvd4    = 4'($urandom());
        dvs4    = 4'($urandom());
    endtask

    task automatic wait_done4();
        int n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("done4_seen", 64'(done4), 64'd1);
    endtask

    // scoreboards
    always @(negedge clk) begin
        logic [64:0] e;
        int a;
        if (done32_prev) check("done32_pulse", 64'(done32), 64'd0);
        if (done32) begin
            if (exp32_q.size() == 0) begin
                check("done32_unexpected", 64'(done32), 64'd0);
            end else begin
                e = exp32_q.pop_front();
                a = acc32_q.pop_front();
                check("quo32", 64'(quo32), 64'(e[31:0]));
                check("rem32", 64'(rem32), 64'(e[63:32]));
                check("dbz32", 64'(dbz32), 64'(e[64]));
                check("lat32", 64'(cyc - a), 64'd33);
                check("busy32_at_done", 64'(busy32), 64'd0);
            end
        end
        done32_prev = done32;
    end

    always @(negedge clk) begin
        logic [8:0] e;
        int a;
        if (done4_prev) check("done4_pulse", 64'(done4), 64'd0);
        if (done4) begin
            if (exp4_q.size() == 0) begin
                check("done4_unexpected", 64'(done4), 64'd0);
            end else begin
                e = exp4_q.pop_front();
                a = acc4_q.pop_front();
                check("quo4", 64'(quo4), 64'(e[3:0]));
                check("rem4", 64'(rem4), 64'(e[7:4]));
                check("dbz4", 64'(dbz4), 64'(e[8]));
                check("lat4", 64'(cyc - a), 64'd5);
            end
        end
        done4_prev = done4;
    end

    initial begin
        int dones;
        reset = 1'b1;
        start32 = 1'b0; signed32 = 1'b0; dvd32 = '0; dvs32 = '0;
        start4 = 1'b0;  signed4 = 1'b0;  dvd4 = '0;  dvs4 = '0;
        repeat (3) @(negedge clk);
        check("rst_quo32", 64'(quo32), 64'd0);
        check("rst_rem32", 64'(rem32), 64'd0);
        check("rst_busy32", 64'(busy32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check("rst_dbz32", 64'(dbz32), 64'd0);
        check("rst_busy4", 64'(busy4), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic unsigned, signed sign rules, divide by zero, overflow
        drive32(1'b0, 32'd100, 32'd7);                 wait_done32(); @(negedge clk);
        drive32(1'b1, 32'hFFFF_FFF9, 32'd2);           wait_done32(); @(negedge clk);
        drive32(1'b1, 32'd7, 32'hFFFF_FFFE);           wait_done32(); @(negedge clk);
        drive32(1'b0, 32'd5, 32'd0);                   wait_done32(); @(negedge clk);
        drive32(1'b1, 32'd5, 32'd0);                   wait_done32(); @(negedge clk);
        drive32(1'b1, 32'hFFFF_FFF9, 32'd0);           wait_done32(); @(negedge clk);
        drive32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done32(); @(negedge clk);
        drive32(1'b0, 32'hFFFF_FFFF, 32'd1);           wait_done32(); @(negedge clk);
        drive32(1'b0, 32'd3, 32'hFFFF_FFFF);           wait_done32(); @(negedge clk);

        // start while busy is ignored; start in the done cycle is accepted
        drive32(1'b0, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        signed32 = 1'b1; dvd32 = 32'd999; dvs32 = 32'd3; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wait_done32();
        drive32(1'b1, 32'hFFFF_FC18, 32'd7);
        repeat (3) @(negedge clk);
        check("hold_quo32", 64'(quo32), 64'd14);
        check("hold_rem32", 64'(rem32), 64'd2);
        wait_done32();
        @(negedge clk);

        // reset mid-run aborts with no done pulse
        drive32(1'b0, 32'd5000, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        void'(exp32_q.pop_back());
        void'(acc32_q.pop_back());
        check("abort_busy32", 64'(busy32), 64'd0);
        check("abort_quo32", 64'(quo32), 64'd0);
        check("abort_rem32", 64'(rem32), 64'd0);
        dones = 0;
        repeat (40) begin
            if (done32) dones++;
            @(negedge clk);
        end
        check("abort_no_done32", 64'(dones), 64'd0);
        drive32(1'b0, 32'd1234567, 32'd89);            wait_done32(); @(negedge clk);

        // random operands, occasional back-to-back
        for (int i = 0; i < 20; i++) begin
            drive32(1'($urandom_range(0, 1)), $urandom(), (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom());
            wait_done32();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // exhaustive 4-bit sweep, back-to-back
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    drive4(1'(s), 4'(a), 4'(b));
                    wait_done4();
                end
            end
        end
        repeat (3) @(negedge clk);

        check("exp32_left", 64'(exp32_q.size()), 64'd0);
        check("exp4_left", 64'(exp4_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
